// File: rtl/ex_operand_issue_pkg.sv
// Shared ALU control codes, LEGv8 opcode constants and operand helpers for the EX issue stage.
// Latency: none (package: types, constants and pure functions only).
// Backpressure: not applicable.
package ex_operand_issue_pkg;

   // ALU control codes understood by the pipeline ALU.
   typedef enum logic [3:0] {
      ALU_AND          = 4'b0000,
      ALU_OR           = 4'b0001,
      ALU_ADD          = 4'b0010,
      ALU_XOR          = 4'b0011,
      ALU_LSHIFT_LEFT  = 4'b0100,
      ALU_LSHIFT_RIGHT = 4'b0101,
      ALU_SUB          = 4'b0110
   } alu_ctrl_e;

   // Main-control ALUOp encodings.
   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_CBZ   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   // 11-bit opcodes (instr[31:21]) decoded under ALUOp 10.
   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
   localparam logic [10:0] OPC_EOR = 11'b11001010000;
   localparam logic [10:0] OPC_LSL = 11'b11010011011;
   localparam logic [10:0] OPC_LSR = 11'b11010011010;

   // I-type opcodes are only 10 bits wide; bit 21 belongs to the immediate.
   localparam logic [9:0] OPC_ADDI = 10'b1001000100;
   localparam logic [9:0] OPC_SUBI = 10'b1101000100;

   // Forwarding mux select encodings (11 is reserved and behaves as register).
   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   // Which immediate field the instruction carries.
   typedef enum logic [1:0] {
      IMM_NONE  = 2'b00,
      IMM_SHAMT = 2'b01,
      IMM_ALU12 = 2'b10,
      IMM_D9    = 2'b11
   } imm_kind_e;

   // Builds the 64-bit immediate from the raw instruction word.
   function automatic logic [63:0] gen_imm(input imm_kind_e kind, input logic [31:0] instr);
      logic [63:0] imm;
      imm = 64'd0;
      case (kind)
         IMM_SHAMT: imm = {58'd0, instr[15:10]};
         IMM_ALU12: imm = {52'd0, instr[21:10]};
         IMM_D9:    imm = {{55{instr[20]}}, instr[20:12]};
         default:   imm = 64'd0;
      endcase
      return imm;
   endfunction

   // Forwarding mux shared by both operand paths.
   function automatic logic [63:0] fwd_pick(input logic [1:0]  sel,
                                            input logic [63:0] reg_val,
                                            input logic [63:0] exmem,
                                            input logic [63:0] memwb);
      logic [63:0] val;
      case (sel)
         FWD_EXMEM: val = exmem;
         FWD_MEMWB: val = memwb;
         default:   val = reg_val;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/ex_operand_issue_alu_ctrl_decode.sv
// ALU control decoder: maps ALUOp and the LEGv8 opcode to an ALU code, immediate kind and illegal flag.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   aluop    in  2   main-control ALUOp
//   opcode   in  11  instr[31:21]
//   ctrl     out 4   ALU control code
//   imm_sel  out 1   instruction always takes its immediate as operand B (shifts, ADDI/SUBI)
//   illegal  out 1   opcode not decodable under ALUOp 10, or reserved ALUOp
//   imm_kind out 2   which immediate field to extract
module ex_operand_issue_alu_ctrl_decode
   import ex_operand_issue_pkg::*;
(
   input  logic [1:0]  aluop,
   input  logic [10:0] opcode,
   output logic [3:0]  ctrl,
   output logic        imm_sel,
   output logic        illegal,
   output imm_kind_e   imm_kind
);

   always_comb begin
      ctrl     = ALU_ADD;
      imm_sel  = 1'b0;
      illegal  = 1'b0;
      imm_kind = IMM_NONE;
      case (aluop)
         ALUOP_MEM: begin
            // Load/store address: base + sign-extended 9-bit offset.
            ctrl     = ALU_ADD;
            imm_kind = IMM_D9;
         end
         ALUOP_CBZ: begin
            ctrl = ALU_SUB;
         end
         ALUOP_RTYPE: begin
            if (opcode == OPC_ADD) begin
               ctrl = ALU_ADD;
            end else if (opcode == OPC_SUB) begin
               ctrl = ALU_SUB;
            end else if (opcode == OPC_AND) begin
               ctrl = ALU_AND;
            end else if (opcode == OPC_ORR) begin
               ctrl = ALU_OR;
            end else if (opcode == OPC_EOR) begin
               ctrl = ALU_XOR;
            end else if (opcode == OPC_LSL) begin
               ctrl     = ALU_LSHIFT_LEFT;
               imm_sel  = 1'b1;
               imm_kind = IMM_SHAMT;
            end else if (opcode == OPC_LSR) begin
               ctrl     = ALU_LSHIFT_RIGHT;
               imm_sel  = 1'b1;
               imm_kind = IMM_SHAMT;
            end else if (opcode[10:1] == OPC_ADDI) begin
               ctrl     = ALU_ADD;
               imm_sel  = 1'b1;
               imm_kind = IMM_ALU12;
            end else if (opcode[10:1] == OPC_SUBI) begin
               ctrl     = ALU_SUB;
               imm_sel  = 1'b1;
               imm_kind = IMM_ALU12;
            end else begin
               ctrl    = ALU_ADD;
               illegal = 1'b1;
            end
         end
         default: begin
            // Reserved ALUOp: harmless ADD, flagged illegal.
            ctrl    = ALU_ADD;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ex_operand_issue.sv
// EX operand issue: ID/EX register for the ALU inputs, immediate select, opcode decode and result forwarding.
// Latency: ID fields reach the ALU one cycle after capture; forward data affects alu_a/alu_b in the same cycle.
// Backpressure: stall holds the ID/EX register, flush loads a bubble (flush wins over stall).
//
// Ports:
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   id_valid/id_instr/id_aluop/
//   id_alusrc/id_rd_a/id_rd_b        decoded instruction and register-file reads from ID
//   stall, flush                     hazard-unit hold / bubble controls
//   fwd_a_sel, fwd_b_sel             forwarding selects: 00 reg, 10 EX/MEM, 01 MEM/WB, 11 reg
//   exmem_result, memwb_result       forwarded results
//   ex_valid, alu_a, alu_b, alu_ctrl ALU drive and EX-stage valid
//   ex_store_data                    forwarded Rt for stores
//   ex_illegal                       undecodable instruction in a valid EX slot
//
// Only DATA_W = 64 is supported; CTRL_W must match the 4-bit ALU code.
module ex_operand_issue
   import ex_operand_issue_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [31:0]       id_instr,
   input  logic [1:0]        id_aluop,
   input  logic              id_alusrc,
   input  logic [DATA_W-1:0] id_rd_a,
   input  logic [DATA_W-1:0] id_rd_b,
   input  logic              stall,
   input  logic              flush,
   input  logic [1:0]        fwd_a_sel,
   input  logic [1:0]        fwd_b_sel,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              ex_illegal
);

   // Decoder outputs for the instruction currently in ID.
   logic [3:0] dec_ctrl;
   logic       dec_imm_sel;
   logic       dec_illegal;
   imm_kind_e  dec_imm_kind;

   // ID/EX register.
   logic              valid_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic              illegal_q;
   logic              imm_sel_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] ra_q;
   logic [DATA_W-1:0] rb_q;
   logic              cbz_q;

   // Forwarded register operands.
   logic [DATA_W-1:0] fa;
   logic [DATA_W-1:0] fb;

   ex_operand_issue_alu_ctrl_decode u_alu_ctrl_decode (
      .aluop    (id_aluop),
      .opcode   (id_instr[31:21]),
      .ctrl     (dec_ctrl),
      .imm_sel  (dec_imm_sel),
      .illegal  (dec_illegal),
      .imm_kind (dec_imm_kind)
   );

   // Flush clears everything, including data, so a bubble presents the same
   // operand picture as a freshly reset stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         ctrl_q    <= CTRL_W'(ALU_ADD);
         illegal_q <= 1'b0;
         imm_sel_q <= 1'b0;
         imm_q     <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         cbz_q     <= 1'b0;
      end else if (flush) begin
         valid_q   <= 1'b0;
         ctrl_q    <= CTRL_W'(ALU_ADD);
         illegal_q <= 1'b0;
         imm_sel_q <= 1'b0;
         imm_q     <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         cbz_q     <= 1'b0;
      end else if (!stall) begin
         valid_q   <= id_valid;
         ctrl_q    <= CTRL_W'(dec_ctrl);
         illegal_q <= dec_illegal;
         // Shifts and ADDI/SUBI always use their immediate even if main control
         // left ALUSrc clear.
         imm_sel_q <= id_alusrc | dec_imm_sel;
         imm_q     <= DATA_W'(gen_imm(dec_imm_kind, id_instr));
         ra_q      <= id_rd_a;
         rb_q      <= id_rd_b;
         cbz_q     <= (id_aluop == ALUOP_CBZ);
      end
   end

   // Forwarding is applied after the register so results produced this cycle
   // by MEM/WB reach the ALU without an extra stall.
   assign fa = DATA_W'(fwd_pick(fwd_a_sel, 64'(ra_q), 64'(exmem_result), 64'(memwb_result)));
   assign fb = DATA_W'(fwd_pick(fwd_b_sel, 64'(rb_q), 64'(exmem_result), 64'(memwb_result)));

   // CBZ tests Rt: route it to A and subtract zero so ALU Zero means Rt==0.
   assign alu_a         = cbz_q ? fb : fa;
   assign alu_b         = cbz_q ? '0 : (imm_sel_q ? imm_q : fb);
   assign alu_ctrl      = ctrl_q;
   assign ex_store_data = fb;
   assign ex_valid      = valid_q;
   assign ex_illegal    = illegal_q & valid_q;

endmodule

// File: tb/tb_ex_operand_issue.sv
// Scoreboard bench for ex_operand_issue: directed test-plan cases then randomized traffic.
// Expected outputs come from an instruction-level model of the EX slot.
// Monitor compares every cycle an expectation is queued.
module tb_ex_operand_issue;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [1:0]  id_aluop;
   logic        id_alusrc;
   logic [63:0] id_rd_a;
   logic [63:0] id_rd_b;
   logic        stall;
   logic        flush;
   logic [1:0]  fwd_a_sel;
   logic [1:0]  fwd_b_sel;
   logic [63:0] exmem_result;
   logic [63:0] memwb_result;
   logic        ex_valid;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [3:0]  alu_ctrl;
   logic [63:0] ex_store_data;
   logic        ex_illegal;

   int ncmp = 0;
   int nerr = 0;

   ex_operand_issue #(.DATA_W(64), .CTRL_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_instr      (id_instr),
      .id_aluop      (id_aluop),
      .id_alusrc     (id_alusrc),
      .id_rd_a       (id_rd_a),
      .id_rd_b       (id_rd_b),
      .stall         (stall),
      .flush         (flush),
      .fwd_a_sel     (fwd_a_sel),
      .fwd_b_sel     (fwd_b_sel),
      .exmem_result  (exmem_result),
      .memwb_result  (memwb_result),
      .ex_valid      (ex_valid),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_ctrl      (alu_ctrl),
      .ex_store_data (ex_store_data),
      .ex_illegal    (ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction sitting in the EX slot, as seen from ID when it was captured.
   typedef struct {
      bit        vld;
      bit [31:0] instr;
      bit [1:0]  aluop;
      bit        alusrc;
      bit [63:0] a;
      bit [63:0] b;
   } slot_t;

   typedef struct {
      bit        vld;
      bit        ill;
      bit [3:0]  ctrl;
      bit [63:0] a;
      bit [63:0] b;
      bit [63:0] sd;
   } exp_t;

   slot_t ex_slot;
   exp_t  sbq[$];

   function automatic slot_t empty_slot();
      slot_t s;
      s.vld = 0; s.instr = 0; s.aluop = 0; s.alusrc = 0; s.a = 0; s.b = 0;
      return s;
   endfunction

   function automatic bit [63:0] fwd(bit [1:0] sel, bit [63:0] v, bit [63:0] exm, bit [63:0] mwb);
      if (sel == 2'b10) return exm;
      if (sel == 2'b01) return mwb;
      return v;
   endfunction

   // What the ALU should see for slot s given this cycle's forwarding inputs.
   function automatic exp_t predict(slot_t s, bit [1:0] fa, bit [1:0] fb, bit [63:0] exm, bit [63:0] mwb);
      exp_t      e;
      bit [10:0] opc;
      bit [63:0] imm;
      bit [63:0] va;
      bit [63:0] vb;
      bit        cbz;
      bit        ill;
      bit [3:0]  ctrl;
      opc  = s.instr[31:21];
      imm  = 0;
      cbz  = 0;
      ill  = 0;
      ctrl = 4'd2;
      case (s.aluop)
         2'b00: imm = {{55{s.instr[20]}}, s.instr[20:12]};
         2'b01: begin ctrl = 4'd6; cbz = 1; end
         2'b10: begin
            if      (opc == 11'b10001011000) ctrl = 4'd2;
            else if (opc == 11'b11001011000) ctrl = 4'd6;
            else if (opc == 11'b10001010000) ctrl = 4'd0;
            else if (opc == 11'b10101010000) ctrl = 4'd1;
            else if (opc == 11'b11001010000) ctrl = 4'd3;
            else if (opc == 11'b11010011011) begin ctrl = 4'd4; imm = 64'(s.instr[15:10]); end
            else if (opc == 11'b11010011010) begin ctrl = 4'd5; imm = 64'(s.instr[15:10]); end
            else if (opc[10:1] == 10'b1001000100) begin ctrl = 4'd2; imm = 64'(s.instr[21:10]); end
            else if (opc[10:1] == 10'b1101000100) begin ctrl = 4'd6; imm = 64'(s.instr[21:10]); end
            else ill = 1;
         end
         default: ill = 1;
      endcase
      va = fwd(fa, s.a, exm, mwb);
      vb = fwd(fb, s.b, exm, mwb);
      e.vld  = s.vld;
      e.ill  = ill && s.vld;
      e.ctrl = ctrl;
      e.a    = cbz ? vb : va;
      e.b    = cbz ? 64'd0 : (s.alusrc ? imm : vb);
      e.sd   = vb;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model of the EX slot: flush inserts a bubble, stall holds, otherwise capture ID.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_slot = empty_slot();
      end else if (flush) begin
         ex_slot = empty_slot();
      end else if (!stall) begin
         ex_slot.vld    = id_valid;
         ex_slot.instr  = id_instr;
         ex_slot.aluop  = id_aluop;
         ex_slot.alusrc = id_alusrc;
         ex_slot.a      = id_rd_a;
         ex_slot.b      = id_rd_b;
      end
   end

   // Monitor: compares DUT outputs against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("ex_valid",      64'(ex_valid),   64'(e.vld));
         chk("ex_illegal",    64'(ex_illegal), 64'(e.ill));
         chk("alu_ctrl",      64'(alu_ctrl),   64'(e.ctrl));
         chk("alu_a",         alu_a,           e.a);
         chk("alu_b",         alu_b,           e.b);
         chk("ex_store_data", ex_store_data,   e.sd);
      end
   end

   // Drives one cycle of stimulus and queues the expectation for the slot now in EX.
   task automatic drive(input bit v, input bit [31:0] ins, input bit [1:0] op, input bit src,
                        input bit [63:0] ra, input bit [63:0] rb, input bit st, input bit fl,
                        input bit [1:0] fa, input bit [1:0] fb, input bit [63:0] exm, input bit [63:0] mwb);
      @(negedge clk);
      id_valid = v; id_instr = ins; id_aluop = op; id_alusrc = src;
      id_rd_a = ra; id_rd_b = rb; stall = st; flush = fl;
      fwd_a_sel = fa; fwd_b_sel = fb; exmem_result = exm; memwb_result = mwb;
      #1;
      sbq.push_back(predict(ex_slot, fa, fb, exm, mwb));
   endtask

   task automatic idle(input bit st);
      drive(0, 32'd0, 2'b00, 0, 64'd0, 64'd0, st, 0, 2'b00, 2'b00, 64'd0, 64'd0);
   endtask

   task automatic rand_instr(output bit [31:0] ins, output bit [1:0] op, output bit src);
      bit [31:0] r;
      bit [10:0] ropc [5];
      int        k;
      ropc[0] = 11'b10001011000; ropc[1] = 11'b11001011000; ropc[2] = 11'b10001010000;
      ropc[3] = 11'b10101010000; ropc[4] = 11'b11001010000;
      r = $urandom;
      k = $urandom_range(0, 9);
      if (k <= 4) begin
         ins = {ropc[$urandom_range(0, 4)], r[20:0]}; op = 2'b10; src = 0;
      end else if (k == 5) begin
         ins = {(r[31] ? 11'b11010011011 : 11'b11010011010), r[20:0]}; op = 2'b10; src = 1;
      end else if (k == 6) begin
         ins = {(r[31] ? 10'b1001000100 : 10'b1101000100), r[21:0]}; op = 2'b10; src = 1;
      end else if (k == 7) begin
         ins = {(r[31] ? 11'b11111000010 : 11'b11111000000), r[20:0]}; op = 2'b00; src = 1;
      end else if (k == 8) begin
         ins = {8'b10110100, r[23:0]}; op = 2'b01; src = 0;
      end else begin
         ins = r; op = r[0] ? 2'b11 : 2'b10; src = 0;
      end
   endtask

   initial begin
      bit [31:0] ins;
      bit [1:0]  op;
      bit        src;
      bit [63:0] ra;
      bit [63:0] rb;
      bit [31:0] i_eor;

      rst_n = 1; id_valid = 0; id_instr = 0; id_aluop = 0; id_alusrc = 0;
      id_rd_a = 0; id_rd_b = 0; stall = 0; flush = 0; fwd_a_sel = 0; fwd_b_sel = 0;
      exmem_result = 0; memwb_result = 0;
      i_eor = {11'b11001010000, 5'd5, 6'd0, 5'd6, 5'd7};

      // Reset asserted mid-cycle, observed before any clock edge.
      #1 rst_n = 0;
      #1;
      chk("reset_ex_valid", 64'(ex_valid), 64'd0);
      chk("reset_alu_ctrl", 64'(alu_ctrl), 64'h2);
      chk("reset_ex_illegal", 64'(ex_illegal), 64'd0);
      chk("reset_alu_a", alu_a, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;

      // ADD X1,X2,X3
      drive(1, {11'b10001011000, 5'd3, 6'd0, 5'd2, 5'd1}, 2'b10, 0, 64'd5, 64'd7, 0, 0, 2'b00, 2'b00, 64'd0, 64'd0);
      idle(0);
      #1;
      chk("add_alu_a", alu_a, 64'd5);
      chk("add_alu_b", alu_b, 64'd7);
      chk("add_ctrl", 64'(alu_ctrl), 64'h2);
      chk("add_valid", 64'(ex_valid), 64'd1);

      // SUBI with immediate 0xFFF
      drive(1, {10'b1101000100, 12'hFFF, 5'd1, 5'd2}, 2'b10, 1, 64'h1000, 64'd3, 0, 0, 2'b00, 2'b00, 64'd0, 64'd0);
      idle(0);
      #1;
      chk("subi_alu_b", alu_b, 64'hFFF);
      chk("subi_ctrl", 64'(alu_ctrl), 64'h6);

      // LDUR with negative offset, base forwarded from EX/MEM
      drive(1, {11'b11111000010, 9'h1F8, 2'b00, 5'd3, 5'd4}, 2'b00, 1, 64'h100, 64'd0, 0, 0, 2'b00, 2'b00, 64'd0, 64'd0);
      drive(0, 32'd0, 2'b00, 0, 64'd0, 64'd0, 0, 0, 2'b10, 2'b00, 64'h40, 64'd0);
      #1;
      chk("ldur_alu_b", alu_b, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("ldur_fwd_a", alu_a, 64'h40);

      // EOR then stall+flush together: flush wins
      drive(1, i_eor, 2'b10, 0, 64'hA5, 64'h5A, 0, 0, 2'b00, 2'b00, 64'd0, 64'd0);
      drive(1, {11'b10001011000, 21'd0}, 2'b10, 0, 64'd1, 64'd2, 1, 1, 2'b00, 2'b00, 64'd0, 64'd0);
      idle(0);
      #1;
      chk("flush_ex_valid", 64'(ex_valid), 64'd0);

      // EOR held by three stall cycles
      drive(1, i_eor, 2'b10, 0, 64'h1234, 64'h4321, 0, 0, 2'b00, 2'b00, 64'd0, 64'd0);
      for (int k = 0; k < 4; k++) begin
         drive(1, {11'b11001011000, 21'd0}, 2'b10, 0, 64'd9, 64'd9, (k < 3), 0, 2'b00, 2'b00, 64'd0, 64'd0);
         #1;
         chk("stall_ctrl", 64'(alu_ctrl), 64'h3);
         chk("stall_alu_a", alu_a, 64'h1234);
      end

      // CBZ with Rt forwarded from MEM/WB
      drive(1, {8'b10110100, 19'd0, 5'd9}, 2'b01, 0, 64'd123, 64'd0, 0, 0, 2'b00, 2'b00, 64'd0, 64'd0);
      drive(0, 32'd0, 2'b00, 0, 64'd0, 64'd0, 0, 0, 2'b00, 2'b01, 64'd0, 64'd9);
      #1;
      chk("cbz_alu_a", alu_a, 64'd9);
      chk("cbz_alu_b", alu_b, 64'd0);
      chk("cbz_ctrl", 64'(alu_ctrl), 64'h6);

      // Unknown opcode under ALUOp 10
      drive(1, {11'h7FF, 21'd0}, 2'b10, 0, 64'd1, 64'd2, 0, 0, 2'b00, 2'b00, 64'd0, 64'd0);
      idle(0);
      #1;
      chk("illegal_flag", 64'(ex_illegal), 64'd1);
      chk("illegal_ctrl", 64'(alu_ctrl), 64'h2);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rand_instr(ins, op, src);
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         drive(($urandom_range(0, 7) != 0), ins, op, src, ra, rb,
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               {$urandom, $urandom}, {$urandom, $urandom});
      end

      // Reset mid-cycle while a valid EOR is in EX
      drive(1, i_eor, 2'b10, 0, 64'd1, 64'd2, 0, 0, 2'b00, 2'b00, 64'd0, 64'd0);
      idle(0);
      #2;
      rst_n = 0;
      #1;
      chk("midreset_ex_valid", 64'(ex_valid), 64'd0);
      chk("midreset_alu_ctrl", 64'(alu_ctrl), 64'h2);
      chk("midreset_ex_illegal", 64'(ex_illegal), 64'd0);

      repeat (3) @(negedge clk);
      #3;
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
